// File: rtl/vmask_iter.sv
// vmask_iter: turns one predicate mask per handshake into a stream of active
// element indices, lowest first. Optional out_popcnt under VMASK_ITER_POPCNT_EN.
module vmask_iter #(
  parameter int NUM_ELEMENTS = 32,
  parameter int IDX_W        = $clog2(NUM_ELEMENTS),
  parameter int TAG_W        = 5
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_ELEMENTS-1:0] in_mask,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_last,
  output logic                    out_empty
`ifdef VMASK_ITER_POPCNT_EN
  ,
  output logic [IDX_W:0]          out_popcnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_ZERO = 2'd2;

  localparam logic [NUM_ELEMENTS-1:0] MASK_ZERO = {NUM_ELEMENTS{1'b0}};
  localparam logic [NUM_ELEMENTS-1:0] MASK_ONE  = {{(NUM_ELEMENTS-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]        IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [TAG_W-1:0]        TAG_ZERO  = {TAG_W{1'b0}};

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_ELEMENTS-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = IDX_ZERO;
    for (int i = NUM_ELEMENTS - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

`ifdef VMASK_ITER_POPCNT_EN
  function automatic logic [IDX_W:0] pop_count(input logic [NUM_ELEMENTS-1:0] m);
    logic [IDX_W:0] cnt;
    cnt = {(IDX_W+1){1'b0}};
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, m[i]};
    end
    return cnt;
  endfunction
`endif

  logic [1:0]              state_r;
  logic [1:0]              state_nxt_s;
  logic [NUM_ELEMENTS-1:0] rem_r;
  logic [NUM_ELEMENTS-1:0] rem_nxt_s;
  logic [NUM_ELEMENTS-1:0] rem_clr_s;
  logic [TAG_W-1:0]        tag_r;
  logic [TAG_W-1:0]        tag_nxt_s;
  logic                    one_hot_s;
  logic                    fire_s;
  logic                    accept_s;
`ifdef VMASK_ITER_POPCNT_EN
  logic [IDX_W:0]          pop_r;
  logic [IDX_W:0]          pop_nxt_s;
`endif

  // rem & (rem-1) drops the lowest set bit; zero result means a single bit remained.
  assign rem_clr_s = rem_r & (rem_r - MASK_ONE);
  assign one_hot_s = (rem_r != MASK_ZERO) && (rem_clr_s == MASK_ZERO);

  // Output beat decode from registered state only.
  always_comb begin
    out_valid = 1'b0;
    out_idx   = IDX_ZERO;
    out_last  = 1'b0;
    out_empty = 1'b0;
    case (state_r)
      ST_ITER: begin
        out_valid = 1'b1;
        out_idx   = lowest_idx(rem_r);
        out_last  = one_hot_s;
        out_empty = 1'b0;
      end
      ST_ZERO: begin
        out_valid = 1'b1;
        out_idx   = IDX_ZERO;
        out_last  = 1'b1;
        out_empty = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
        out_idx   = IDX_ZERO;
        out_last  = 1'b0;
        out_empty = 1'b0;
      end
    endcase
  end

  assign out_tag  = tag_r;
  assign fire_s   = out_valid & out_ready;
  // A final beat firing frees the slot in the same cycle, so masks chain without a bubble.
  assign in_ready = ~flush & ((state_r == ST_IDLE) | (fire_s & out_last));
  assign accept_s = in_valid & in_ready;

`ifdef VMASK_ITER_POPCNT_EN
  assign out_popcnt = pop_r;
`endif

  // Next-state, remaining-mask and tag selection.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    tag_nxt_s   = tag_r;
`ifdef VMASK_ITER_POPCNT_EN
    pop_nxt_s   = pop_r;
`endif
    if (flush) begin
      state_nxt_s = ST_IDLE;
      rem_nxt_s   = MASK_ZERO;
`ifdef VMASK_ITER_POPCNT_EN
      pop_nxt_s   = {(IDX_W+1){1'b0}};
`endif
    end else if (accept_s) begin
      state_nxt_s = (in_mask == MASK_ZERO) ? ST_ZERO : ST_ITER;
      rem_nxt_s   = in_mask;
      tag_nxt_s   = in_tag;
`ifdef VMASK_ITER_POPCNT_EN
      pop_nxt_s   = pop_count(in_mask);
`endif
    end else if (fire_s) begin
      case (state_r)
        ST_ITER: begin
          rem_nxt_s   = rem_clr_s;
          state_nxt_s = one_hot_s ? ST_IDLE : ST_ITER;
        end
        ST_ZERO: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
      rem_r   <= MASK_ZERO;
      tag_r   <= TAG_ZERO;
`ifdef VMASK_ITER_POPCNT_EN
      pop_r   <= {(IDX_W+1){1'b0}};
`endif
    end else begin
      state_r <= state_nxt_s;
      rem_r   <= rem_nxt_s;
      tag_r   <= tag_nxt_s;
`ifdef VMASK_ITER_POPCNT_EN
      pop_r   <= pop_nxt_s;
`endif
    end
  end

endmodule

// File: doc/vmask_iter.md
# vmask_iter

Mask-driven element sequencer sitting directly downstream of the mask unit (`masku`). It accepts one NUM_ELEMENTS-bit predicate mask per transaction over a valid/ready handshake. It then emits the index of every set bit, lowest index first, one index per cycle, so the lanes only process active elements. An all-zero mask produces a single "empty" beat, so every accepted mask yields at least one output beat and downstream tag tracking stays simple.

## Interface
- NUM_ELEMENTS, 32, mask width in elements; power of two, ≥2
- IDX_W, $clog2(NUM_ELEMENTS), index width
- TAG_W, 5, width of the opaque tag carried with each mask (e.g. vd / row_id)

- CLK  input  1  clock; all state updates on the rising edge
- nRST  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort; drops the in-flight mask
- in_valid  input  1  in_mask/in_tag valid (driven from masku_out)
- in_ready  output  1  block can accept a mask this cycle
- in_mask  input  NUM_ELEMENTS  predicate mask; bit i = element i active
- in_tag  input  TAG_W  tag echoed on every output beat
- out_valid  output  1  out_* fields valid
- out_ready  input  1  consumer accepts the beat
- out_idx  output  IDX_W  active element index (0 on empty beat)
- out_tag  output  TAG_W  tag of the current mask
- out_last  output  1  final beat of the current mask
- out_empty  output  1  mask was all zero; no element active

Clocking and reset are fixed: one clock; reset is asynchronous and active-low.

## Operation
- State machine states: IDLE, ITER, ZERO.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid: latch in_mask into `rem` and in_tag into `tag`.
  - Go to ZERO if in_mask==0, else ITER.
- **ITER**
  - out_valid=1.
  - out_idx = index of lowest set bit in `rem`.
  - out_last=1 when `rem` has exactly one bit set; out_empty=0.
  - On out fire (out_valid & out_ready): clear that bit in `rem`.
  - If out_last: go to IDLE, unless a back-to-back accept occurs (below).
- **ZERO**
  - out_valid=1, out_idx=0, out_last=1, out_empty=1.
  - On out fire: go to IDLE, unless a back-to-back accept occurs.
- **Back-to-back:** in_ready = IDLE | (out fire & out_last).
  - When a final beat fires and in_valid=1 in the same cycle, the new mask is latched.
  - Next state is ITER or ZERO per the new mask, with no IDLE bubble.
- **Output stability:** out_* hold while out_valid & !out_ready; `rem` changes only on fire.
- **flush**
  - Highest priority: next state IDLE, `rem` cleared.
  - No input accepted that cycle; in_ready is forced to 0 while flush=1.
  - Any current output beat is discarded, even if out_ready=1; the consumer must ignore a fire coincident with flush.
- **Priority encoder:** combinational over `rem`.
  - The one-bit check is (rem & (rem-1))==0 with rem≠0.
  - Full-mask case (all ones) emits indices 0..NUM_ELEMENTS-1 with out_last on index NUM_ELEMENTS-1.
- in_mask/in_tag are sampled only on accept; changes at other times are ignored.

## Timing
- **Reset values** (nRST low, asynchronous):
  - State IDLE; `rem`=0, `tag`=0.
  - Outputs: in_ready=1, out_valid=0, out_idx=0, out_tag=0, out_last=0, out_empty=0 (and out_popcnt=0 when compiled in).
- **Reset mid-operation:** the mask is lost and no partial beat is emitted after release.
- **Latency:** first beat valid the cycle after accept (1-cycle latency).
- **Throughput:** 1 index/cycle with out_ready held high.
  - A mask with k set bits occupies k cycles; an all-zero mask occupies 1 cycle.
  - Masks stream back-to-back with zero idle cycles.
- **Outputs:** out_* are driven combinationally from registered state only; there is no combinational path from out_ready to out_valid/out_idx.
- **in_ready:** depends combinationally on out_ready (back-to-back path).

## Configuration
- Macro VMASK_ITER_POPCNT_EN.
- **Defined:** adds output out_popcnt [IDX_W:0].
  - Holds the population count of the current mask, registered at accept.
  - Constant for all beats of that mask; 0 on the ZERO beat.
  - Resets to 0; flush clears it.
- **Undefined:** port, counter logic and register are absent; all other behaviour is identical.

## Test plan
- **Sparse mask:** accept in_mask=0x8000_0011, tag=3, out_ready=1.
  - Beats idx 0, 4, 31 on consecutive cycles with out_tag=3; out_last only on 31.
  - in_ready=1 on the idx-31 cycle.
- **Zero mask:** in_mask=0.
  - One beat: out_empty=1, out_last=1, out_idx=0; then IDLE.
  - popcnt=0 if enabled.
- **Back-to-back:** mask 0x1, then 0x6 presented immediately.
  - Beats 0(last), 1, 2(last) on three consecutive cycles with no bubble; tags switch on the second beat.
- **Backpressure:** mask 0x0000_00F0, out_ready toggling 1,0,0,1,...
  - Indices 4..7 each held stable while stalled; none dropped or duplicated.
- **Full mask:** in_mask=0xFFFF_FFFF.
  - 32 beats, indices 0..31 in order; out_last on 31.
  - popcnt=32 if enabled.
- **Flush/reset mid-mask:** mask 0xF0F0, flush asserted after 2 beats.
  - Next cycle out_valid=0 and in_ready=1.
  - Repeat with nRST pulsed low asynchronously: all outputs immediately at reset values.
